// File: rtl/adder_tree_pipe.sv
// Pipelined binary adder tree: an input register stage followed by LEVELS registered
// adder levels, each level one bit wider than the last, with a global valid/ready stall.
module adder_tree_pipe #(
    parameter int unsigned WIDTH  = 48,
    parameter int unsigned LEVELS = 3,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [(1 << LEVELS)*WIDTH-1:0]    in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH+LEVELS-1:0]           out_sum
);

    localparam int unsigned N = 1 << LEVELS;

    // Bit offset of level k inside the flat stage_data bus (levels packed low to high).
    function automatic int unsigned lvl_off(input int unsigned k);
        int unsigned off;
        off = 0;
        for (int unsigned i = 0; i < k; i++) begin
            off += (N >> i) * (WIDTH + i);
        end
        return off;
    endfunction

    localparam int unsigned TotalBits = lvl_off(LEVELS + 1);
    localparam int unsigned OutOff    = lvl_off(LEVELS);

    logic [TotalBits-1:0] stage_data;
    logic [LEVELS:0]      stage_vld_q;
    logic                 advance;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = stage_vld_q[LEVELS];
    assign out_sum   = stage_data[OutOff +: WIDTH+LEVELS];

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld_q <= '0;
        end else if (advance) begin
            stage_vld_q <= {stage_vld_q[LEVELS-1:0], in_valid};
        end
    end

    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int unsigned NK  = N >> k;
        localparam int unsigned WK  = WIDTH + k;
        localparam int unsigned Off = lvl_off(k);

        logic [NK*WK-1:0] data_d;
        logic [NK*WK-1:0] data_q;

        if (k == 0) begin : g_in
            assign data_d = in_data;
        end else begin : g_add
            localparam int unsigned WP   = WK - 1;
            localparam int unsigned OffP = lvl_off(k - 1);

            for (genvar j = 0; j < NK; j++) begin : g_pair
                logic [WP-1:0] a;
                logic [WP-1:0] b;

                assign a = stage_data[OffP + (2*j)*WP +: WP];
                assign b = stage_data[OffP + (2*j+1)*WP +: WP];

                // One guard bit per level means the sum can never overflow.
                if (SIGNED) begin : g_sx
                    assign data_d[j*WK +: WK] = {a[WP-1], a} + {b[WP-1], b};
                end else begin : g_zx
                    assign data_d[j*WK +: WK] = {1'b0, a} + {1'b0, b};
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
            end else if (advance) begin
                data_q <= data_d;
            end
        end

        assign stage_data[Off +: NK*WK] = data_q;
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe: default unsigned and signed trees share stimulus,
// plus a LEVELS=1/WIDTH=1 and a LEVELS=6/WIDTH=128 instance driven with random traffic.
module tb_adder_tree_pipe;

    localparam int W  = 48;
    localparam int L  = 3;
    localparam int N  = 8;
    localparam int OW = W + L;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             vin;
    logic             ordy;
    logic [N*W-1:0]   din;
    logic             d_rdy, d_ov;
    logic [OW-1:0]    d_sum;
    logic             s_rdy, s_ov;
    logic [OW-1:0]    s_sum;

    logic             p_vin;
    logic             p_ordy;
    logic [1:0]       p1_din;
    logic [8191:0]    p6_din;
    logic             p1_rdy, p1_ov;
    logic [1:0]       p1_sum;
    logic             p6_rdy, p6_ov;
    logic [133:0]     p6_sum;

    int n_tests = 0;
    int n_fail  = 0;

    logic [133:0] q_u[$];
    logic [133:0] q_s[$];
    logic [133:0] q_1[$];
    logic [133:0] q_6[$];

    adder_tree_pipe #(.WIDTH(W), .LEVELS(L), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(vin), .in_ready(d_rdy), .in_data(din),
        .out_valid(d_ov), .out_ready(ordy), .out_sum(d_sum)
    );

    adder_tree_pipe #(.WIDTH(W), .LEVELS(L), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(vin), .in_ready(s_rdy), .in_data(din),
        .out_valid(s_ov), .out_ready(ordy), .out_sum(s_sum)
    );

    adder_tree_pipe #(.WIDTH(1), .LEVELS(1), .SIGNED(1'b0)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(p_vin), .in_ready(p1_rdy), .in_data(p1_din),
        .out_valid(p1_ov), .out_ready(p_ordy), .out_sum(p1_sum)
    );

    adder_tree_pipe #(.WIDTH(128), .LEVELS(6), .SIGNED(1'b0)) u_l6 (
        .clk(clk), .rst(rst), .in_valid(p_vin), .in_ready(p6_rdy), .in_data(p6_din),
        .out_valid(p6_ov), .out_ready(p_ordy), .out_sum(p6_sum)
    );

    task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Flat accumulation of all operands, truncated to the output width.
    function automatic logic [133:0] model(input logic [8191:0] data, input int n, input int w,
                                           input int lv, input bit sgn);
        logic [133:0] acc;
        logic [133:0] op;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            op = '0;
            for (int b = 0; b < w; b++) op[b] = data[i*w+b];
            if (sgn && op[w-1]) for (int b = w; b < 134; b++) op[b] = 1'b1;
            acc = acc + op;
        end
        for (int b = w + lv; b < 134; b++) acc[b] = 1'b0;
        return acc;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q_u.delete(); q_s.delete(); q_1.delete(); q_6.delete();
        end else begin
            if (d_ov && ordy) begin
                if (q_u.size() == 0) check("u_unexpected", 1, 0);
                else check("u_sum", d_sum, q_u.pop_front());
            end
            if (s_ov && ordy) begin
                if (q_s.size() == 0) check("s_unexpected", 1, 0);
                else check("s_sum", s_sum, q_s.pop_front());
            end
            if (p1_ov && p_ordy) begin
                if (q_1.size() == 0) check("l1_unexpected", 1, 0);
                else check("l1_sum", p1_sum, q_1.pop_front());
            end
            if (p6_ov && p_ordy) begin
                if (q_6.size() == 0) check("l6_unexpected", 1, 0);
                else check("l6_sum", p6_sum, q_6.pop_front());
            end
            if (vin && d_rdy)   q_u.push_back(model(din, N, W, L, 1'b0));
            if (vin && s_rdy)   q_s.push_back(model(din, N, W, L, 1'b1));
            if (p_vin && p1_rdy) q_1.push_back(model(p1_din, 2, 1, 1, 1'b0));
            if (p_vin && p6_rdy) q_6.push_back(model(p6_din, 64, 128, 6, 1'b0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns after the edge that accepts it; vin is left asserted.
    task automatic send(input logic [N*W-1:0] d);
        logic acc;
        vin = 1'b1;
        din = d;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = d_rdy;
            tick();
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    // Single beat with an idle pipe: checks both sums and the edge count to out_valid.
    task automatic run_one(input string tag, input logic [N*W-1:0] d,
                           input logic [OW-1:0] exp_u, input logic [OW-1:0] exp_s);
        int lat;
        lat = -1;
        din = d;
        vin = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            vin = 1'b0;
            if (d_ov && lat < 0) begin
                lat = i;
                check({tag, "_u"}, d_sum, exp_u);
                check({tag, "_s"}, s_sum, exp_s);
            end
        end
        check({tag, "_lat"}, lat, L + 1);
    endtask

    logic [N*W-1:0] beat;
    logic [OW-1:0]  hold;
    int             cnt, t, lat1, lat6;

    initial begin
        rst = 1'b1; vin = 1'b0; din = '0; ordy = 1'b1;
        p_vin = 1'b0; p_ordy = 1'b1; p1_din = '0; p6_din = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ov", d_ov, 0);
        check("rst_sum", d_sum, 0);
        check("rst_rdy", d_rdy, 1);
        check("rst_l6_sum", p6_sum, 0);
        tick();

        for (int i = 0; i < N; i++) beat[i*W +: W] = '1;
        run_one("umax", beat, 51'h7_FFFF_FFFF_FFF8, 51'h7_FFFF_FFFF_FFF8);

        for (int i = 0; i < N; i++) beat[i*W +: W] = (i < 4) ? 48'hFFFF_FFFF_FFFF : 48'd1;
        run_one("mixed", beat, 51'h4_0000_0000_0000, 51'h0);

        // Back-to-back stream, outputs must form one unbroken run.
        fork
            begin
                for (int b = 0; b < 16; b++) begin
                    for (int i = 0; i < N; i++) beat[i*W +: W] = 48'(b + i);
                    send(beat);
                end
                vin = 1'b0;
            end
            begin
                cnt = 0;
                t = 0;
                while (!d_ov && t < 30) begin @(negedge clk); t++; end
                for (int k = 0; k < 16; k++) begin
                    if (d_ov) cnt++;
                    @(negedge clk);
                end
                check("b2b_run", cnt, 16);
            end
        join
        repeat (6) tick();

        // Backpressure while four beats are in flight.
        ordy = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < N; i++) beat[i*W +: W] = 48'(1000 * (b + 1) + 7 * i);
            send(beat);
        end
        vin = 1'b0;
        t = 0;
        while (!d_ov && t < 20) begin @(negedge clk); t++; end
        hold = d_sum;
        for (int k = 0; k < 5; k++) begin
            check("bp_in_ready", d_rdy, 0);
            check("bp_out_valid", d_ov, 1);
            check("bp_sum_stable", d_sum, hold);
            @(negedge clk);
        end
        @(posedge clk);
        #1 ordy = 1'b1;
        repeat (8) tick();

        // Reset with three beats in flight.
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < N; i++) beat[i*W +: W] = 48'(55 + b * 3 + i);
            send(beat);
        end
        vin = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_ov", d_ov, 0);
        check("mrst_sum", d_sum, 0);
        check("mrst_s_sum", s_sum, 0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (d_ov || s_ov) cnt++;
            @(negedge clk);
        end
        check("mrst_stale", cnt, 0);
        tick();

        // Parameter sweep: latency first, then random traffic with random backpressure.
        p1_din = 2'($urandom);
        for (int c = 0; c < 256; c++) p6_din[c*32 +: 32] = $urandom;
        p_vin = 1'b1;
        lat1 = -1;
        lat6 = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            p_vin = 1'b0;
            if (p1_ov && lat1 < 0) lat1 = i;
            if (p6_ov && lat6 < 0) lat6 = i;
        end
        check("l1_lat", lat1, 2);
        check("l6_lat", lat6, 7);
        for (int b = 0; b < 80; b++) begin
            p_vin = 1'($urandom_range(0, 1));
            p_ordy = ($urandom_range(0, 3) != 0);
            p1_din = 2'($urandom);
            for (int c = 0; c < 256; c++) p6_din[c*32 +: 32] = $urandom;
            if (b % 10 == 0) for (int c = 0; c < 256; c++) p6_din[c*32 +: 32] = '1;
            tick();
        end
        p_vin = 1'b0;
        p_ordy = 1'b1;

        t = 0;
        while ((q_u.size() + q_s.size() + q_1.size() + q_6.size()) != 0 && t < 100) begin
            tick();
            t++;
        end
        check("drain_u", q_u.size(), 0);
        check("drain_s", q_s.size(), 0);
        check("drain_l1", q_1.size(), 0);
        check("drain_l6", q_6.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder_tree_pipe.md
ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 48, giving the width of each input operand in bits (legal range 1..128).
REQ-002 The block SHALL have parameter LEVELS, default 3, giving the number of adder levels, so N = 2**LEVELS inputs (legal range 1..6).
REQ-003 The block SHALL have parameter SIGNED, default 0: 0 treats operands as unsigned, 1 treats them as two's complement.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port in_valid, input, 1 bit: in_data carries a beat this cycle.
REQ-007 Port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 Port in_data, input, N*WIDTH bits: packed operands; operand i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port out_valid, output, 1 bit: out_sum holds a valid result.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-011 Port out_sum, output, WIDTH+LEVELS bits: the registered sum of the N operands.

Function
REQ-012 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-013 The pipeline SHALL be one input register stage (N x WIDTH) followed by LEVELS registered adder levels; the level-LEVELS register SHALL drive out_sum directly.
REQ-014 Level k (1..LEVELS) SHALL hold N/2**k partial sums, each WIDTH+k bits wide, each formed by adding pair (2j, 2j+1) of level k-1.
REQ-015 Each level SHALL extend its operands by one bit before adding: zero-extend when SIGNED=0, sign-extend when SIGNED=1; no overflow or truncation is permitted at any level.
REQ-016 Each stage SHALL carry a valid bit that advances together with its data.
REQ-017 The global advance condition SHALL be advance = !out_valid || out_ready.
REQ-018 in_ready SHALL equal advance, combinationally.
REQ-019 When advance=1, every stage SHALL load from the stage before it; the input stage loads in_data and a valid bit equal to in_valid.
REQ-020 When advance=0, every stage's data and valid bit SHALL hold; no beat is lost or duplicated.
REQ-021 Latency: a beat accepted on edge t SHALL appear on out_sum with out_valid=1 after edge t+LEVELS, provided advance=1 on every edge in between.
REQ-022 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-023 Bubbles (in_valid=0 while advance=1) SHALL propagate as valid=0 stages; out_sum content under out_valid=0 is don't-care but SHALL be deterministic.
REQ-024 Results SHALL leave in acceptance order; with out_ready held at 1, the output sequence equals the input sequence delayed by LEVELS+1 edges.
REQ-025 With out_valid=1 and out_ready=1 on the same edge, the current result SHALL retire and the next stage SHALL load in that same cycle.

Reset
REQ-026 While rst=1 on a rising edge, all stage valid bits SHALL clear to 0, and all data registers, including out_sum, SHALL clear to 0.
REQ-027 After reset, out_valid=0 and out_sum=0; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-028 rst asserted mid-operation SHALL discard all in-flight beats; rst takes priority over advance and in_valid.
REQ-029 No beat SHALL be accepted on an edge where rst=1.

Verification
REQ-030 The bench SHALL cover these scenarios (defaults WIDTH=48, LEVELS=3 unless stated):
- Unsigned max: all 8 operands 0xFFFF_FFFF_FFFF, out_ready=1 -> out_sum = 51'h7_FFFF_FFFF_FFF8, out_valid after exactly 3 edges past the accepting edge.
- SIGNED=0 vs SIGNED=1: operands 0-3 = 0xFFFF_FFFF_FFFF, operands 4-7 = 1 -> unsigned gives 51'h4_0000_0000_0000; signed gives 0.
- Back-to-back stream: 16 consecutive beats with operand i = beat index + i -> outputs equal 8*index + 28 in order, one per cycle, with no gaps.
- Backpressure: hold out_ready=0 for 5 cycles while a 4-beat stream is in flight -> in_ready=0 throughout, out_sum stable, all 4 results delivered in order once out_ready=1.
- Reset mid-flight: assert rst for 1 cycle with 3 beats in flight -> out_valid=0 and out_sum=0 on the next cycle, and no stale result ever appears.
- Parameter sweep: LEVELS=1 with WIDTH=1 and LEVELS=6 with WIDTH=128 on random data, checked against a reference model -> exact match, latency LEVELS+1.
